// File: rtl/gate_op_arbiter.sv
// gate_op_arbiter: round-robin arbiter that shares one bitwise basic-gate unit
// (AND/OR/NOT/NAND/NOR/XOR/XNOR) among NREQ requesters.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. Requesters may raise or drop req_valid at any time before the grant.
// rsp_valid/rsp_id/rsp_y/rsp_err stay stable from assertion until the edge
// where rsp_ready is also high.
//
// The arbiter runs one transaction at a time: IDLE (grant) -> EXEC (compute)
// -> RESP (hold the response). The FSM state can be observed through busy.
//
// Optional feature macro: GATE_ARB_STATS_EN adds per-requester saturating
// grant counters on the grant_cnt output.
module gate_op_arbiter #(
  parameter int NREQ  = 4,
  parameter int W     = 1,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [3*NREQ-1:0]        req_op,
  input  logic [W*NREQ-1:0]        req_a,
  input  logic [W*NREQ-1:0]        req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [W-1:0]             rsp_y,
  output logic                     rsp_err,
  output logic                     busy
`ifdef GATE_ARB_STATS_EN
  ,
  output logic [CNT_W*NREQ-1:0]    grant_cnt
`endif
);

  localparam int ID_W = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_idx;
  logic            grant_found;
  logic            accept;

  logic [ID_W-1:0] g_q;
  logic [2:0]      op_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;

  logic [W-1:0]    y_calc;
  logic            err_calc;

  // Cyclic priority search starting at rr_ptr. Iterating from the far end
  // downwards lets the nearest valid requester overwrite any farther one.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  assign accept = (state == IDLE) && grant_found;

  // Ready is one-hot on the granted requester, only in IDLE and out of reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && accept) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_found) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Capture the granted requester's id, opcode and operands on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q  <= '0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      g_q  <= grant_idx;
      op_q <= req_op[3*int'(grant_idx) +: 3];
      a_q  <= req_a[W*int'(grant_idx) +: W];
      b_q  <= req_b[W*int'(grant_idx) +: W];
    end
  end

  // Basic-gate datapath on the captured operands; opcode 7 is reserved.
  always_comb begin
    y_calc   = '0;
    err_calc = 1'b0;
    case (op_q)
      3'd0:    y_calc = a_q & b_q;
      3'd1:    y_calc = a_q | b_q;
      3'd2:    y_calc = ~a_q;
      3'd3:    y_calc = ~(a_q & b_q);
      3'd4:    y_calc = ~(a_q | b_q);
      3'd5:    y_calc = a_q ^ b_q;
      3'd6:    y_calc = ~(a_q ^ b_q);
      default: err_calc = 1'b1;
    endcase
  end

  // Response registers and round-robin pointer; the pointer advances only
  // when a response is consumed, so a reset mid-flight restarts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= '0;
      rsp_err   <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_id    <= g_q;
        rsp_y     <= y_calc;
        rsp_err   <= err_calc;
      end else if ((state == RESP) && rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
        rr_ptr    <= (int'(g_q) == NREQ - 1) ? '0 : g_q + 1'b1;
      end
    end
  end

`ifdef GATE_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_cnt
    // Saturating count of accept edges for requester i.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q[i] <= '0;
      end else if (accept && (int'(grant_idx) == i) && (cnt_q[i] != '1)) begin
        cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
    assign grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_gate_op_arbiter.sv
// tb_gate_op_arbiter: directed test of gate_op_arbiter with NREQ=4, W=1.
// Inputs change on the falling edge and outputs are checked there, away
// from the rising clock edge.
module tb_gate_op_arbiter;

  localparam int NREQ  = 4;
  localparam int W     = 1;
  localparam int CNT_W = 16;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_op;
  logic [W*NREQ-1:0] req_a;
  logic [W*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_y;
  logic              rsp_err;
  logic              busy;
`ifdef GATE_ARB_STATS_EN
  logic [CNT_W*NREQ-1:0] grant_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int exp_cnt [NREQ];

  gate_op_arbiter #(.NREQ(NREQ), .W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_err   (rsp_err),
    .busy      (busy)
`ifdef GATE_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One transaction from a single requester, consumer always ready.
  task automatic do_txn(input int id, input logic [2:0] op, input logic a, input logic b,
                        input logic exp_y, input logic exp_err, input string tag);
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_op[3*id +: 3] = op;
    req_a[id] = a;
    req_b[id] = b;
    rsp_ready = 1'b1;
    #1;
    check({tag, ".ready"}, 32'(req_ready), 32'(1 << id));
    @(posedge clk);
    exp_cnt[id]++;
    @(negedge clk);
    req_valid = '0;
    check({tag, ".exec_busy"}, 32'(busy), 32'd1);
    check({tag, ".exec_valid"}, 32'(rsp_valid), 32'd0);
    step();
    check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".id"}, 32'(rsp_id), 32'(id));
    check({tag, ".y"}, 32'(rsp_y), 32'(exp_y));
    check({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
    step();
    check({tag, ".idle_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ".idle_busy"}, 32'(busy), 32'd0);
  endtask

  // Truth tables for ops 0..6, bit index = {a,b}.
  logic [3:0] tt [7];
  logic [1:0] seq_id [5];
  logic       seq_y [5];

  initial begin
    tt = '{4'b1000, 4'b1110, 4'b0011, 4'b0111, 4'b0001, 4'b0110, 4'b1001};
    seq_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    seq_y  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    foreach (exp_cnt[i]) exp_cnt[i] = 0;

    // Reset state, with requests pending to show ready stays low in reset.
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    #1;
    check("rst.ready", 32'(req_ready), 32'd0);
    check("rst.valid", 32'(rsp_valid), 32'd0);
    check("rst.id", 32'(rsp_id), 32'd0);
    check("rst.y", 32'(rsp_y), 32'd0);
    check("rst.err", 32'(rsp_err), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single AND request from requester 0.
    do_txn(0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, "t1");

    // Restart so the round-robin pointer begins at 0.
    rst_n = 1'b0;
    foreach (exp_cnt[i]) exp_cnt[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // All four requesters held valid: grants rotate 0,1,2,3,0.
    // Requester i uses op i with a=1, b=0.
    for (int i = 0; i < NREQ; i++) begin
      req_op[3*i +: 3] = 3'(i);
      req_a[i] = 1'b1;
      req_b[i] = 1'b0;
    end
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1;
      check("t2.ready", 32'(req_ready), 32'(1 << seq_id[n]));
      @(posedge clk);
      exp_cnt[seq_id[n]]++;
      @(negedge clk);
      check("t2.exec_ready", 32'(req_ready), 32'd0);
      step();
      check("t2.id", 32'(rsp_id), 32'(seq_id[n]));
      check("t2.y", 32'(rsp_y), 32'(seq_y[n]));
      step();
    end

    // Consumer stalls for 5 cycles in RESP (pointer is now 1).
    rsp_ready = 1'b0;
    #1;
    check("t3.ready", 32'(req_ready), 32'b0010);
    @(posedge clk);
    exp_cnt[1]++;
    @(negedge clk);
    step();
    for (int n = 0; n < 5; n++) begin
      check("t3.valid", 32'(rsp_valid), 32'd1);
      check("t3.id", 32'(rsp_id), 32'd1);
      check("t3.y", 32'(rsp_y), 32'd1);
      check("t3.busy", 32'(busy), 32'd1);
      check("t3.hold_ready", 32'(req_ready), 32'd0);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    check("t3.rel_valid", 32'(rsp_valid), 32'd0);
    check("t3.rel_busy", 32'(busy), 32'd0);

    // Reserved opcode then NOT from requester 2.
    do_txn(2, 3'd7, 1'b1, 1'b1, 1'b0, 1'b1, "t4.rsv");
    do_txn(2, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, "t4.not");

    // Reset during RESP (pointer is now 3, so requester 3 is granted first).
    req_op[2:0] = 3'd0;
    req_a[0] = 1'b1;
    req_b[0] = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    #1;
    check("t5.ready", 32'(req_ready), 32'b1000);
    @(posedge clk);
    exp_cnt[3]++;
    @(negedge clk);
    step();
    check("t5.resp_valid", 32'(rsp_valid), 32'd1);
    check("t5.resp_id", 32'(rsp_id), 32'd3);
    rst_n = 1'b0;
    foreach (exp_cnt[i]) exp_cnt[i] = 0;
    #1;
    check("t5.rst_valid", 32'(rsp_valid), 32'd0);
    check("t5.rst_busy", 32'(busy), 32'd0);
    check("t5.rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t5.post_ready", 32'(req_ready), 32'b0001);
    @(posedge clk);
    exp_cnt[0]++;
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    check("t5.post_valid", 32'(rsp_valid), 32'd1);
    check("t5.post_id", 32'(rsp_id), 32'd0);
    check("t5.post_y", 32'(rsp_y), 32'd0);
    step();

    // Sweep of ops 0..6 over every (a,b); requester index follows {a,b}.
    for (int op = 0; op < 7; op++) begin
      for (int ab = 0; ab < 4; ab++) begin
        logic [1:0] abv;
        logic [3:0] row;
        abv = 2'(ab);
        row = tt[op];
        do_txn(ab, 3'(op), abv[1], abv[0], row[ab], 1'b0, "t6");
      end
    end

`ifdef GATE_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) begin
      check("stats.cnt", 32'(grant_cnt[i*CNT_W +: CNT_W]), 32'(exp_cnt[i]));
    end
`endif
    $display("accepts since last reset: %0d %0d %0d %0d",
             exp_cnt[0], exp_cnt[1], exp_cnt[2], exp_cnt[3]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
